// File: rtl/hold_mux_n.sv
// -----------------------------------------------------------------------------
// hold_mux_n
//
// Registered N-to-1 selector with value hold. Each rising edge where at least
// one select line is high loads the lowest-indexed selected channel into the
// output register. When no select is high the output holds its last loaded
// value. Alongside the datapath it reports which channel was loaded last,
// flags and counts cycles where several selects were high at once, and counts
// how long the output has been holding.
//
// Typical placement: between the controller's select decode and datapath
// register / ALU operand inputs (PC source, ALU operand selection, ...).
//
// Parameters
//   WIDTH        data width per channel (>= 1)
//   CHANNELS     number of input channels (2..16)
//   RESET_VALUE  value loaded into data_out on reset or clear
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous, active-high reset
//   in_data         packed channel inputs; channel i = in_data[i*WIDTH +: WIDTH]
//   sel             select lines; bit i selects channel i (lowest index wins)
//   clr             synchronous clear; same end state as reset, beats sel
//   data_out        registered selected value
//   out_valid       high once any channel has been loaded since reset/clear
//   sel_idx         index of the last loaded channel
//   conflict        registered pulse: two or more sel bits were high last edge
//   conflict_count  saturating count of conflict cycles
//   hold_count      saturating count of consecutive edges with no select
//
// Every output comes straight from a flop; there is no combinational path
// from any input to any output.
// -----------------------------------------------------------------------------
module hold_mux_n #(
  parameter int                 WIDTH       = 8,
  parameter int                 CHANNELS    = 3,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
  localparam int                IW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS*WIDTH-1:0]   in_data,
  input  logic [CHANNELS-1:0]         sel,
  input  logic                        clr,
  output logic [WIDTH-1:0]            data_out,
  output logic                        out_valid,
  output logic [IW-1:0]               sel_idx,
  output logic                        conflict,
  output logic [7:0]                  conflict_count,
  output logic [15:0]                 hold_count
);

  localparam logic [7:0]  CONFLICT_MAX = 8'hFF;
  localparam logic [15:0] HOLD_MAX     = 16'hFFFF;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] data_q,           data_d;
  logic             valid_q,          valid_d;
  logic [IW-1:0]    idx_q,            idx_d;
  logic             conflict_q,       conflict_d;
  logic [7:0]       conflict_count_q, conflict_count_d;
  logic [15:0]      hold_count_q,     hold_count_d;

  // ---------------------------------------------------------------------------
  // Select decode: winning channel, its data, and multi-select detection
  // ---------------------------------------------------------------------------
  logic             any_sel;
  logic             multi_sel;
  logic [IW-1:0]    win_idx;
  logic [WIDTH-1:0] win_data;

  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // before any conditional assignment; otherwise a path that skips the
    // assignment would infer a latch.
    win_idx  = '0;
    win_data = '0;
    any_sel  = |sel;
    // Clearing the lowest set bit leaves something only if two or more
    // bits were set, which avoids a full popcount.
    multi_sel = |(sel & (sel - CHANNELS'(1)));
    // Scan from the top down so the lowest selected index is written last
    // and therefore wins.
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (sel[i]) begin
        win_idx  = IW'(i);
        win_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    data_d           = data_q;
    valid_d          = valid_q;
    idx_d            = idx_q;
    conflict_d       = 1'b0;
    conflict_count_d = conflict_count_q;
    hold_count_d     = hold_count_q;

    if (clr) begin
      // Clear wins over any select, including a conflicting one.
      data_d           = RESET_VALUE;
      valid_d          = 1'b0;
      idx_d            = '0;
      conflict_d       = 1'b0;
      conflict_count_d = '0;
      hold_count_d     = '0;
    end else begin
      if (any_sel) begin
        data_d       = win_data;
        idx_d        = win_idx;
        valid_d      = 1'b1;
        hold_count_d = '0;
      end else if (hold_count_q != HOLD_MAX) begin
        hold_count_d = hold_count_q + 16'd1;
      end

      conflict_d = multi_sel;
      if (multi_sel && (conflict_count_q != CONFLICT_MAX)) begin
        conflict_count_d = conflict_count_q + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      data_q           <= RESET_VALUE;
      valid_q          <= 1'b0;
      idx_q            <= '0;
      conflict_q       <= 1'b0;
      conflict_count_q <= '0;
      hold_count_q     <= '0;
    end else begin
      data_q           <= data_d;
      valid_q          <= valid_d;
      idx_q            <= idx_d;
      conflict_q       <= conflict_d;
      conflict_count_q <= conflict_count_d;
      hold_count_q     <= hold_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign data_out       = data_q;
  assign out_valid      = valid_q;
  assign sel_idx        = idx_q;
  assign conflict       = conflict_q;
  assign conflict_count = conflict_count_q;
  assign hold_count     = hold_count_q;

endmodule
